// File: rtl/serial_diff_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_diff_comparator
// Brief    : Bit-serial x/y inequality check, MSB first. Builds the XOR
//            difference mask one bit per clock. Also reports diff/equal and
//            the index of the most significant differing bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_diff_comparator #(
  parameter int WIDTH = 5,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             diff,
  output logic             equal,
  output logic [WIDTH-1:0] mask,
  output logic [IDXW-1:0]  first_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [IDXW-1:0] c_CNT_TOP = IDXW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] yr_q, yr_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             diff_q, diff_d;
  logic             equal_q, equal_d;
  logic [IDXW-1:0]  fidx_q, fidx_d;

  logic [WIDTH-1:0] w_xor;
  logic             w_bit;
  logic [WIDTH-1:0] w_bit_mask;

  // Difference bit currently under the counter, and its one-hot mask position
  always_comb begin
    w_xor      = xr_q ^ yr_q;
    w_bit      = w_xor[cnt_q];
    w_bit_mask = {{(WIDTH-1){1'b0}}, w_bit} << cnt_q;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: SHIFT runs until the counter reaches bit 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    busy = (state_q == S_SHIFT) || (state_q == S_DONE);
    done = (state_q == S_DONE);
  end

  // Datapath next values: capture on start, fold in one bit per SHIFT edge
  always_comb begin
    xr_d    = xr_q;
    yr_d    = yr_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    diff_d  = diff_q;
    equal_d = equal_q;
    fidx_d  = fidx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          xr_d    = x;
          yr_d    = y;
          cnt_d   = c_CNT_TOP;
          mask_d  = '0;
          diff_d  = 1'b0;
          equal_d = 1'b0;
          fidx_d  = '1;
        end
      end
      S_SHIFT: begin
        mask_d = mask_q | w_bit_mask;
        // Bits arrive MSB first, so the first hit is the most significant
        if (w_bit && !diff_q) begin
          fidx_d = cnt_q;
          diff_d = 1'b1;
        end
        if (cnt_q == '0) begin
          equal_d = ~(diff_q | w_bit);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset wipes any partial result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xr_q    <= '0;
      yr_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      diff_q  <= 1'b0;
      equal_q <= 1'b0;
      fidx_q  <= '1;
    end else begin
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      diff_q  <= diff_d;
      equal_q <= equal_d;
      fidx_q  <= fidx_d;
    end
  end

  assign diff      = diff_q;
  assign equal     = equal_q;
  assign mask      = mask_q;
  assign first_idx = fidx_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_diff_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_diff_comparator
// Brief    : Directed self-checking bench for serial_diff_comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_diff_comparator;

  localparam int WIDTH = 5;
  localparam int IDXW  = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             diff;
  logic             equal;
  logic [WIDTH-1:0] mask;
  logic [IDXW-1:0]  first_idx;

  int r_checks;
  int r_failures;

  serial_diff_comparator #(.WIDTH(WIDTH), .IDXW(IDXW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .equal     (equal),
    .mask      (mask),
    .first_idx (first_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic d, input logic e,
                              input logic [WIDTH-1:0] m, input logic [IDXW-1:0] f);
    check({tag, ".diff"},  32'(diff),      32'(d));
    check({tag, ".equal"}, 32'(equal),     32'(e));
    check({tag, ".mask"},  32'(mask),      32'(m));
    check({tag, ".fidx"},  32'(first_idx), 32'(f));
  endtask

  // Full operation: start edge, WIDTH processing edges, then return to IDLE
  task automatic run_op(input string tag, input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                        input logic d, input logic e,
                        input logic [WIDTH-1:0] m, input logic [IDXW-1:0] f);
    x = xv; y = yv; start = 1'b1;
    tick();
    start = 1'b0;
    x = ~xv; y = yv;
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      check({tag, ".done_low"}, 32'(done), 32'd0);
      check({tag, ".busy"},     32'(busy), 32'd1);
    end
    tick();
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_done"}, 32'(busy), 32'd1);
    check_result(tag, d, e, m, f);
    tick();
    check({tag, ".done_drop"}, 32'(done), 32'd0);
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    check_result({tag, ".hold"}, d, e, m, f);
  endtask

  initial begin
    r_checks   = 0;
    r_failures = 0;
    reset = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    tick();
    tick();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check_result("rst", 1'b0, 1'b0, 5'b00000, 3'b111);
    reset = 1'b0;
    tick();

    run_op("eq",   5'b10101, 5'b10101, 1'b0, 1'b1, 5'b00000, 3'b111);
    run_op("lsb",  5'b10011, 5'b10010, 1'b1, 1'b0, 5'b00001, 3'b000);
    run_op("msb",  5'b10101, 5'b00100, 1'b1, 1'b0, 5'b10001, 3'b100);

    // Start while busy: second request must be dropped
    x = 5'b11111; y = 5'b00000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    x = 5'b00000; y = 5'b00000; start = 1'b1;
    tick();
    start = 1'b0;
    check("busyst.busy3", 32'(busy), 32'd1);
    tick();
    check("busyst.busy4", 32'(busy), 32'd1);
    check("busyst.nodone4", 32'(done), 32'd0);
    tick();
    check("busyst.done", 32'(done), 32'd1);
    check_result("busyst", 1'b1, 1'b0, 5'b11111, 3'b100);
    tick();
    check("busyst.idle", 32'(busy), 32'd0);
    tick();
    check("busyst.noreq", 32'(busy), 32'd0);
    check_result("busyst.hold", 1'b1, 1'b0, 5'b11111, 3'b100);

    // Reset mid-SHIFT after two processing edges
    x = 5'b10101; y = 5'b01010; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("midrst.partial", 32'(mask), 32'b11000);
    reset = 1'b1;
    #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check_result("midrst", 1'b0, 1'b0, 5'b00000, 3'b111);
    tick();
    reset = 1'b0;
    tick();
    run_op("postrst", 5'b00010, 5'b00000, 1'b1, 1'b0, 5'b00010, 3'b001);

    // Start held high: done after edges 5, 12, 19 relative to first start edge
    x = 5'b01000; y = 5'b00000; start = 1'b1;
    tick();
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (i == 5 || i == 12 || i == 19) begin
        check($sformatf("held.done%0d", i), 32'(done), 32'd1);
        check_result($sformatf("held%0d", i), 1'b1, 1'b0, 5'b01000, 3'b011);
      end else begin
        check($sformatf("held.nodone%0d", i), 32'(done), 32'd0);
      end
    end
    start = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
    $finish;
  end

endmodule
`default_nettype wire
